// File: rtl/obstacle_row_gen_if.sv
// Request/row bus between the game controller and the obstacle row generator.
// The controller is the master; the generator answers on the slave modport.
interface obstacle_row_gen_if #(
  parameter int board_width  = 9,
  parameter int PAT_WIDTH    = 3,
  parameter int PAT_ROWS     = 4,
  parameter int NUM_PATTERNS = 4,
  parameter int GAP_MAX      = 8
);
  localparam int DIFF_W = $clog2(GAP_MAX + 1);

  logic                                        game_Over;
  logic                                        update_obstacle;
  logic [DIFF_W-1:0]                           difficulty;
  logic [NUM_PATTERNS*PAT_ROWS*PAT_WIDTH-1:0]  pat_table;
  logic [board_width-1:0]                      row_data;
  logic                                        row_strobe;
  logic                                        in_gap;

  modport master (
    output game_Over, update_obstacle, difficulty, pat_table,
    input  row_data, row_strobe, in_gap
  );

  modport slave (
    input  game_Over, update_obstacle, difficulty, pat_table,
    output row_data, row_strobe, in_gap
  );
endinterface

// File: rtl/obstacle_row_gen.sv
// Produces the next top row of the dodge board: a shifted PAT_ROWS-row pattern burst,
// then a run of empty rows whose length shrinks with difficulty. Frozen while game_Over.
module obstacle_row_gen #(
  parameter int board_width  = 9,
  parameter int PAT_WIDTH    = 3,
  parameter int PAT_ROWS     = 4,
  parameter int NUM_PATTERNS = 4,
  parameter int GAP_MAX      = 8,
  parameter int LFSR_WIDTH   = 8,
  parameter logic [LFSR_WIDTH-1:0] SEED = 8'hA5
) (
  input logic              clk,
  input logic              reset,
  obstacle_row_gen_if.slave bus
);

  localparam int DW   = $clog2(GAP_MAX + 1);
  localparam int CMAX = (PAT_ROWS > GAP_MAX) ? PAT_ROWS : GAP_MAX;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PB   = $clog2(NUM_PATTERNS);
  localparam int PBW  = (PB > 0) ? PB : 1;
  localparam int SR   = board_width - PAT_WIDTH + 1;
  localparam int SB   = $clog2(SR);
  localparam int SBW  = (SB > 0) ? SB : 1;
  localparam int TW   = NUM_PATTERNS * PAT_ROWS * PAT_WIDTH;
  localparam int IW   = (TW > 2) ? $clog2(TW) : 1;

  // Maximal-length Fibonacci tap masks; bit i-1 set for polynomial term x^i.
  function automatic logic [63:0] tap_mask(input int width);
    logic [63:0] m;
    case (width)
      4:       m = 64'h000C;
      5:       m = 64'h0014;
      6:       m = 64'h0030;
      7:       m = 64'h0060;
      8:       m = 64'h00B8;
      9:       m = 64'h0110;
      10:      m = 64'h0240;
      11:      m = 64'h0500;
      12:      m = 64'h0829;
      13:      m = 64'h100D;
      14:      m = 64'h2015;
      15:      m = 64'h6000;
      16:      m = 64'hD008;
      default: m = (64'h1 << (width - 1)) | 64'h1;
    endcase
    return m;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] TAPS     = LFSR_WIDTH'(tap_mask(LFSR_WIDTH));
  localparam logic [LFSR_WIDTH-1:0] SEED_EFF = (SEED == '0) ? LFSR_WIDTH'(1) : SEED;

  function automatic logic [PBW-1:0] sel_of(input logic [LFSR_WIDTH-1:0] v);
    logic [PBW-1:0] s;
    s = v[PBW-1:0];
    if (32'(s) >= NUM_PATTERNS) s = s - PBW'(NUM_PATTERNS);
    return s;
  endfunction

  function automatic logic [SBW-1:0] shift_of(input logic [LFSR_WIDTH-1:0] v);
    logic [SBW-1:0] s;
    s = v[4 +: SBW];
    if (32'(s) >= SR) s = s - SBW'(SR);
    return s;
  endfunction

  typedef enum logic {OBST, GAP} state_t;

  state_t                 state;
  logic [CW-1:0]          row_cnt;
  logic [DW-1:0]          gap_len;
  logic [LFSR_WIDTH-1:0]  lfsr;
  logic [PBW-1:0]         pat_sel;
  logic [SBW-1:0]         shift;
  logic [board_width-1:0] row_q;
  logic                   strobe_q;
  logic                   gap_q;

  logic                   advance;
  logic                   last_obst;
  logic                   last_gap;
  logic                   fb;
  logic [DW-1:0]          next_gap_len;
  logic [CW-1:0]          pat_row_idx;
  logic [IW-1:0]          base;
  logic [PAT_WIDTH-1:0]   pat_row;
  logic [board_width-1:0] obst_row;
  logic [LFSR_WIDTH-1:0]  lfsr_next;

  always_comb begin
    advance      = bus.update_obstacle && !bus.game_Over;
    pat_row_idx  = (state == OBST) ? row_cnt : '0;
    base         = IW'((int'(pat_sel) * PAT_ROWS + int'(pat_row_idx)) * PAT_WIDTH);
    pat_row      = bus.pat_table[base +: PAT_WIDTH];
    obst_row     = board_width'(pat_row) << shift;
    last_obst    = (row_cnt == CW'(PAT_ROWS - 1));
    last_gap     = ((32'(row_cnt) + 32'd1) == 32'(gap_len));
    next_gap_len = (bus.difficulty >= DW'(GAP_MAX)) ? DW'(1) : (DW'(GAP_MAX) - bus.difficulty);
    fb           = ^(lfsr & TAPS);
    lfsr_next    = {lfsr[LFSR_WIDTH-2:0], fb};
  end

  // Pattern selection for the next burst uses the LFSR value before this edge's step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= OBST;
      row_cnt  <= '0;
      gap_len  <= DW'(1);
      lfsr     <= SEED_EFF;
      pat_sel  <= sel_of(SEED_EFF);
      shift    <= shift_of(SEED_EFF);
      row_q    <= '0;
      strobe_q <= 1'b0;
      gap_q    <= 1'b0;
    end else begin
      strobe_q <= advance;
      if (advance) begin
        lfsr <= lfsr_next;
        case (state)
          OBST: begin
            row_q <= obst_row;
            if (last_obst) begin
              row_cnt <= '0;
              gap_len <= next_gap_len;
              state   <= GAP;
              gap_q   <= 1'b1;
            end else begin
              row_cnt <= row_cnt + CW'(1);
            end
          end
          GAP: begin
            row_q <= '0;
            if (last_gap) begin
              row_cnt <= '0;
              state   <= OBST;
              gap_q   <= 1'b0;
              pat_sel <= sel_of(lfsr);
              shift   <= shift_of(lfsr);
            end else begin
              row_cnt <= row_cnt + CW'(1);
            end
          end
          default: state <= OBST;
        endcase
      end
    end
  end

  assign bus.row_data   = row_q;
  assign bus.row_strobe = strobe_q;
  assign bus.in_gap     = gap_q;

endmodule

// File: tb/tb_obstacle_row_gen.sv
// Bench for obstacle_row_gen: fixed vector table, directed gap/freeze/reset sequences,
// and a long randomized run compared against a row-by-row behavioural model.
module tb_obstacle_row_gen;

  localparam int BW = 9;
  localparam int PW = 3;
  localparam int PR = 4;
  localparam int NP = 4;
  localparam int GM = 8;

  logic clk;
  logic reset;

  obstacle_row_gen_if #(
    .board_width(BW), .PAT_WIDTH(PW), .PAT_ROWS(PR), .NUM_PATTERNS(NP), .GAP_MAX(GM)
  ) bus ();

  obstacle_row_gen #(
    .board_width(BW), .PAT_WIDTH(PW), .PAT_ROWS(PR), .NUM_PATTERNS(NP), .GAP_MAX(GM),
    .LFSR_WIDTH(8), .SEED(8'hA5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int pat [NP][PR] = '{'{1, 3, 7, 4}, '{2, 7, 5, 2}, '{6, 3, 6, 3}, '{7, 0, 7, 0}};

  // Reference model: rows left in the current phase, the chosen pattern/shift and the LFSR.
  bit m_gap;
  bit m_strobe;
  int m_left;
  int m_sel;
  int m_shift;
  int m_lfsr;
  int m_row;
  int m_burst_rows;

  typedef struct {
    bit upd;
    bit go;
    int diff;
    int row;
    bit gap;
    bit strobe;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic latch_from_lfsr();
    m_sel = m_lfsr % NP;
    m_shift = (m_lfsr / 16) % 8;
    if (m_shift >= BW - PW + 1) m_shift = m_shift - (BW - PW + 1);
  endtask

  task automatic model_reset();
    m_lfsr = 'hA5;
    latch_from_lfsr();
    m_gap = 1'b0;
    m_left = PR;
    m_row = 0;
    m_strobe = 1'b0;
    m_burst_rows = 0;
  endtask

  task automatic model_advance(input int diff);
    int fb;
    if (!m_gap) begin
      m_row = (pat[m_sel][PR - m_left] << m_shift) & 'h1FF;
      m_left--;
      m_burst_rows++;
      if (m_left == 0) begin
        check("burst_len", m_burst_rows, PR);
        m_burst_rows = 0;
        m_gap = 1'b1;
        m_left = (diff >= GM) ? 1 : GM - diff;
      end
    end else begin
      m_row = 0;
      m_left--;
      if (m_left == 0) begin
        m_gap = 1'b0;
        m_left = PR;
        latch_from_lfsr();
      end
    end
    fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
    m_lfsr = ((m_lfsr << 1) | fb) & 'hFF;
  endtask

  task automatic check_output();
    check("row_data", int'(bus.row_data), m_row);
    check("in_gap", int'(bus.in_gap), int'(m_gap));
    check("row_strobe", int'(bus.row_strobe), int'(m_strobe));
  endtask

  task automatic apply_stimulus(input bit upd, input bit go, input bit rst, input int diff);
    @(negedge clk);
    reset = rst;
    bus.update_obstacle = upd;
    bus.game_Over = go;
    bus.difficulty = 4'(diff);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_strobe = upd && !go;
      if (m_strobe) model_advance(diff & 15);
    end
    #1;
    check_output();
  endtask

  task automatic measure_gap(input int diff_burst, input int diff_mid, input int expected,
                             input string name);
    int n;
    repeat (PR) apply_stimulus(1'b1, 1'b0, 1'b0, diff_burst);
    check({name, "_entered"}, int'(bus.in_gap), 1);
    n = 0;
    do begin
      apply_stimulus(1'b1, 1'b0, 1'b0, diff_mid);
      n++;
    end while (bus.in_gap && n < 20);
    check(name, n, expected);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r_hold;
    int g_hold;
    bit upd;
    bit go;
    bit rst;

    reset = 1'b1;
    bus.update_obstacle = 1'b0;
    bus.game_Over = 1'b0;
    bus.difficulty = '0;
    for (int p = 0; p < NP; p++)
      for (int r = 0; r < PR; r++)
        bus.pat_table[(p*PR + r)*PW +: PW] = 3'(pat[p][r]);

    vecs[0] = '{1'b1, 1'b0, 5, 'h008, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 5, 'h01C, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 5, 'h01C, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 5, 'h01C, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 5, 'h014, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 5, 'h008, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 5, 'h000, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 5, 'h000, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 5, 'h000, 1'b0, 1'b1};

    apply_stimulus(1'b0, 1'b0, 1'b1, 5);
    check("reset_row", int'(bus.row_data), 0);
    check("reset_gap", int'(bus.in_gap), 0);
    check("reset_strobe", int'(bus.row_strobe), 0);

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].upd, vecs[i].go, 1'b0, vecs[i].diff);
      check($sformatf("vec%0d_row", i), int'(bus.row_data), vecs[i].row);
      check($sformatf("vec%0d_gap", i), int'(bus.in_gap), int'(vecs[i].gap));
      check($sformatf("vec%0d_strobe", i), int'(bus.row_strobe), int'(vecs[i].strobe));
    end

    apply_stimulus(1'b0, 1'b0, 1'b1, 0);
    measure_gap(0, 0, 8, "gap_d0");
    measure_gap(12, 12, 1, "gap_d12");
    measure_gap(5, 0, 3, "gap_d5_mid_change");

    apply_stimulus(1'b1, 1'b0, 1'b0, 5);
    apply_stimulus(1'b1, 1'b0, 1'b0, 5);
    r_hold = int'(bus.row_data);
    g_hold = int'(bus.in_gap);
    repeat (6) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 5);
      check("freeze_row", int'(bus.row_data), r_hold);
      check("freeze_gap", int'(bus.in_gap), g_hold);
      check("freeze_strobe", int'(bus.row_strobe), 0);
    end
    apply_stimulus(1'b1, 1'b0, 1'b0, 5);

    repeat (10000) begin
      upd = ($urandom_range(0, 9) < 7);
      go  = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 499) == 0);
      apply_stimulus(upd, go, rst, $urandom_range(0, 15));
      check("never_full", int'(bus.row_data == 9'h1FF), 0);
    end

    apply_stimulus(1'b0, 1'b0, 1'b1, 5);
    repeat (PR) apply_stimulus(1'b1, 1'b0, 1'b0, 5);
    apply_stimulus(1'b1, 1'b0, 1'b0, 5);
    check("midgap_in_gap", int'(bus.in_gap), 1);
    apply_stimulus(1'b1, 1'b1, 1'b1, 5);
    check("midgap_reset_row", int'(bus.row_data), 0);
    check("midgap_reset_gap", int'(bus.in_gap), 0);
    check("midgap_reset_strobe", int'(bus.row_strobe), 0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 5);
    check("after_reset_first_row", int'(bus.row_data), 'h008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
